// File: rtl/toll_lane_controller.sv
// Single toll lane sequencer: vehicle detect -> card read -> charge -> gate/reject,
// with saturating plaza statistics. All outputs come straight from flops.
module toll_lane_controller #(
  parameter int FEE_BIKE     = 8,
  parameter int FEE_CAR      = 10,
  parameter int FEE_BUS      = 15,
  parameter int FEE_TRUCK    = 20,
  parameter int CARD_TIMEOUT = 32,
  parameter int GATE_MAX     = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vehicle_detect,
  input  logic [1:0]  vehicle_type,
  input  logic        card_valid,
  input  logic [7:0]  card_balance,
  output logic        card_wr_en,
  output logic [7:0]  card_wr_balance,
  output logic        gate_open,
  output logic        reject,
  output logic        busy,
  output logic [15:0] vehicle_count,
  output logic [7:0]  reject_count,
  output logic [15:0] revenue
);

  typedef enum logic [2:0] {
    IDLE, WAIT_CARD, CHARGE, OPEN, HOLD, REJECT
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  fee_q, fee_d;
  logic [7:0]  bal_q, bal_d;
  logic [7:0]  timer_q, timer_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_bal_q, wr_bal_d;
  logic [15:0] vcnt_q, vcnt_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic [15:0] rev_q, rev_d;
  logic        gate_q, rej_q, busy_q;
  logic [16:0] rev_sum;

  function automatic logic [7:0] fee_of(input logic [1:0] t);
    case (t)
      2'b00:   fee_of = 8'(FEE_BIKE);
      2'b01:   fee_of = 8'(FEE_CAR);
      2'b10:   fee_of = 8'(FEE_BUS);
      default: fee_of = 8'(FEE_TRUCK);
    endcase
  endfunction

  assign rev_sum = {1'b0, rev_q} + {9'b0, fee_q};

  always_comb begin
    state_d  = state_q;
    fee_d    = fee_q;
    bal_d    = bal_q;
    timer_d  = timer_q;
    wr_en_d  = 1'b0;
    wr_bal_d = wr_bal_q;
    vcnt_d   = vcnt_q;
    rcnt_d   = rcnt_q;
    rev_d    = rev_q;
    case (state_q)
      IDLE: begin
        if (vehicle_detect) begin
          fee_d   = fee_of(vehicle_type);
          timer_d = '0;
          state_d = WAIT_CARD;
        end
      end
      WAIT_CARD: begin
        timer_d = timer_q + 8'd1;
        if (!vehicle_detect) begin
          state_d = IDLE;
        end else if (card_valid) begin
          bal_d   = card_balance;
          state_d = CHARGE;
        end else if (timer_q == 8'(CARD_TIMEOUT - 1)) begin
          state_d = REJECT;
          rcnt_d  = (rcnt_q == 8'hFF) ? rcnt_q : rcnt_q + 8'd1;
        end
      end
      CHARGE: begin
        if (bal_q >= fee_q) begin
          state_d  = OPEN;
          wr_en_d  = 1'b1;
          wr_bal_d = bal_q - fee_q;
          vcnt_d   = (vcnt_q == 16'hFFFF) ? vcnt_q : vcnt_q + 16'd1;
          rev_d    = rev_sum[16] ? 16'hFFFF : rev_sum[15:0];
          timer_d  = '0;
        end else begin
          state_d = REJECT;
          rcnt_d  = (rcnt_q == 8'hFF) ? rcnt_q : rcnt_q + 8'd1;
        end
      end
      OPEN: begin
        timer_d = timer_q + 8'd1;
        // Vehicle leaving beats the safety timeout when both land together.
        if (!vehicle_detect)                          state_d = IDLE;
        else if (timer_q == 8'(GATE_MAX - 1))         state_d = HOLD;
      end
      HOLD, REJECT: begin
        if (!vehicle_detect) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      fee_q    <= '0;
      bal_q    <= '0;
      timer_q  <= '0;
      wr_en_q  <= 1'b0;
      wr_bal_q <= '0;
      vcnt_q   <= '0;
      rcnt_q   <= '0;
      rev_q    <= '0;
      gate_q   <= 1'b0;
      rej_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fee_q    <= fee_d;
      bal_q    <= bal_d;
      timer_q  <= timer_d;
      wr_en_q  <= wr_en_d;
      wr_bal_q <= wr_bal_d;
      vcnt_q   <= vcnt_d;
      rcnt_q   <= rcnt_d;
      rev_q    <= rev_d;
      gate_q   <= (state_d == OPEN);
      rej_q    <= (state_d == REJECT);
      busy_q   <= (state_d != IDLE);
    end
  end

  assign card_wr_en      = wr_en_q;
  assign card_wr_balance = wr_bal_q;
  assign gate_open       = gate_q;
  assign reject          = rej_q;
  assign busy            = busy_q;
  assign vehicle_count   = vcnt_q;
  assign reject_count    = rcnt_q;
  assign revenue         = rev_q;

endmodule

// File: tb/tb_toll_lane_controller.sv
// Randomized bench for toll_lane_controller: whole-vehicle scenarios are generated
// and their outcome/timing predicted from the fee rules with plain arithmetic.
module tb_toll_lane_controller;
  localparam int CT = 32;
  localparam int GM = 64;
  localparam int FEES [4] = '{8, 10, 15, 20};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vehicle_detect;
  logic [1:0]  vehicle_type;
  logic        card_valid;
  logic [7:0]  card_balance;
  logic        card_wr_en;
  logic [7:0]  card_wr_balance;
  logic        gate_open, reject, busy;
  logic [15:0] vehicle_count;
  logic [7:0]  reject_count;
  logic [15:0] revenue;

  toll_lane_controller dut (
    .clk(clk), .reset_n(reset_n),
    .vehicle_detect(vehicle_detect), .vehicle_type(vehicle_type),
    .card_valid(card_valid), .card_balance(card_balance),
    .card_wr_en(card_wr_en), .card_wr_balance(card_wr_balance),
    .gate_open(gate_open), .reject(reject), .busy(busy),
    .vehicle_count(vehicle_count), .reject_count(reject_count), .revenue(revenue)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference ledger
  int         m_vc, m_rc, m_rev;
  logic [7:0] m_wrbal;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // {gate_open, reject, busy, card_wr_en}
  task automatic chk_outs(input string tag, input bit g, input bit r, input bit b, input bit w);
    chk(tag, {28'd0, gate_open, reject, busy, card_wr_en}, {28'd0, g, r, b, w});
  endtask

  task automatic chk_ledger(input string tag);
    chk({tag, ".vcount"}, vehicle_count, m_vc);
    chk({tag, ".rcount"}, reject_count, m_rc);
    chk({tag, ".revenue"}, revenue, m_rev);
    chk({tag, ".wrbal"}, card_wr_balance, m_wrbal);
  endtask

  task automatic leave_lane(input string tag);
    vehicle_detect = 1'b0;
    tick;
    chk_outs({tag, ".idle"}, 0, 0, 0, 0);
    chk_ledger(tag);
  endtask

  // mode 0: leaves after c cycles in WAIT_CARD; 1: card on WAIT cycle c; 2: card timeout.
  // dwell: extra cycles the vehicle stays after the gate/reject decision.
  task automatic vehicle(input int t, input int mode, input int c, input int bal, input int dwell);
    int  fee;
    bit  pass;
    fee = FEES[t];
    vehicle_detect = 1'b1;
    vehicle_type   = 2'(t);
    tick;
    chk_outs("arrive", 0, 0, 1, 0);
    vehicle_type = 2'($urandom);
    if (mode == 0) begin
      repeat (c) begin tick; chk_outs("wait", 0, 0, 1, 0); end
      leave_lane("walkaway");
    end else if (mode == 1) begin
      repeat (c) begin tick; chk_outs("wait", 0, 0, 1, 0); end
      card_valid   = 1'b1;
      card_balance = 8'(bal);
      tick;
      // a card pulse during CHARGE must be ignored
      card_valid   = 1'($urandom_range(0, 1));
      card_balance = 8'($urandom);
      chk_outs("charge", 0, 0, 1, 0);
      tick;
      card_valid = 1'b0;
      pass = (bal >= fee);
      if (pass) begin
        m_vc    = (m_vc + 1 > 65535) ? 65535 : m_vc + 1;
        m_rev   = (m_rev + fee > 65535) ? 65535 : m_rev + fee;
        m_wrbal = 8'(bal - fee);
      end else begin
        m_rc = (m_rc + 1 > 255) ? 255 : m_rc + 1;
      end
      chk_outs("decide", pass, !pass, 1, pass);
      chk_ledger("decide");
      for (int i = 1; i <= dwell; i++) begin
        tick;
        chk_outs("dwell", pass && (i < GM), !pass, 1, 0);
      end
      leave_lane("pass");
    end else begin
      repeat (CT - 1) begin tick; chk_outs("wait", 0, 0, 1, 0); end
      tick;
      m_rc = (m_rc + 1 > 255) ? 255 : m_rc + 1;
      chk_outs("timeout", 0, 1, 1, 0);
      chk_ledger("timeout");
      for (int i = 1; i <= dwell; i++) begin
        tick;
        chk_outs("tdwell", 0, 1, 1, 0);
      end
      leave_lane("timeout");
    end
  endtask

  initial begin
    int r, mode, bal, dwell, guard;
    reset_n = 1'b0;
    vehicle_detect = 1'b0;
    vehicle_type = 2'b00;
    card_valid = 1'b0;
    card_balance = 8'd0;
    m_vc = 0; m_rc = 0; m_rev = 0; m_wrbal = 8'd0;
    tick; tick;
    chk_outs("reset", 0, 0, 0, 0);
    chk_ledger("reset");
    reset_n = 1'b1;
    tick;

    // car pays 50 -> 40 written back
    vehicle(1, 1, 0, 50, 3);
    chk("car.wrbal", card_wr_balance, 40);
    chk("car.revenue", revenue, 10);
    // exact balance truck, short bus, bike timeout, walk-away, gate safety
    vehicle(3, 1, 2, 20, 0);
    chk("truck.wrbal", card_wr_balance, 0);
    vehicle(2, 1, 1, 14, 2);
    chk("bus.rcount", reject_count, 1);
    vehicle(0, 2, 0, 0, 1);
    vehicle(1, 0, 5, 0, 0);
    vehicle(1, 1, CT - 1, 100, 70);
    vehicle(3, 0, CT - 1, 0, 0);

    // stray card pulses while idle are ignored
    card_valid = 1'b1; card_balance = 8'd99;
    tick;
    card_valid = 1'b0;
    chk_outs("idlecard", 0, 0, 0, 0);
    chk_ledger("idlecard");

    repeat (400) begin
      r     = $urandom_range(0, 19);
      mode  = (r < 4) ? 0 : (r < 17) ? 1 : 2;
      bal   = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 40);
      dwell = ($urandom_range(0, 15) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 6);
      vehicle($urandom_range(0, 3), mode, $urandom_range(0, CT - 1), bal, dwell);
    end

    // reject counter saturation
    repeat (260) vehicle(2, 1, 0, $urandom_range(0, 14), 0);
    chk("rcount.sat", reject_count, 255);

    // revenue saturation
    guard = 0;
    while (m_rev < 65520 && guard < 4000) begin
      vehicle(3, 1, 0, $urandom_range(20, 255), 0);
      guard++;
    end
    repeat (3) vehicle(1, 1, 0, 60, 0);
    chk("rev.sat", revenue, 65535);

    // async reset with the gate open
    vehicle_detect = 1'b1; vehicle_type = 2'b01;
    tick;
    card_valid = 1'b1; card_balance = 8'd50;
    tick;
    card_valid = 1'b0;
    tick;
    chk_outs("preopen", 1, 0, 1, 1);
    #2 reset_n = 1'b0;
    #1;
    m_vc = 0; m_rc = 0; m_rev = 0; m_wrbal = 8'd0;
    chk_outs("asyncrst", 0, 0, 0, 0);
    chk_ledger("asyncrst");
    vehicle_detect = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick;
    vehicle(1, 1, 3, 50, 2);
    chk("postrst.vcount", vehicle_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
